bitstream_serializer: RTL and testbench

BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

---
 rtl/bitstream_serializer_if.sv | 23 ++
 rtl/bitstream_serializer.sv | 100 ++++++++++
 tb/tb_bitstream_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bitstream_serializer_if.sv
// Upstream word handshake plus serial output bundle for bitstream_serializer.
// master = word source / bit sink, slave = the serializer itself.
interface bitstream_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, last_bit, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, last_bit, busy
    );
endinterface

// File: rtl/bitstream_serializer.sv
// MSB-first parallel-to-serial converter with a one-word holding register so
// consecutive words stream with no idle gap between them.
module bitstream_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    bitstream_serializer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             hr_full_q, hr_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             accept;
    logic             final_bit;

    assign bus.in_ready   = ~hr_full_q & ~reset;
    assign accept         = bus.in_valid & bus.in_ready;
    assign final_bit      = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.last_bit   = last_bit_q;
    assign bus.busy       = (state_q == SHIFT) | hr_full_q;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        hr_d      = hr_q;
        hr_full_d = hr_full_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sr_d    = bus.in_data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (!final_bit) begin
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hr_d      = bus.in_data;
                        hr_full_d = 1'b1;
                    end
                end else if (hr_full_q) begin
                    // Word boundary: pending word takes over with no gap cycle.
                    sr_d      = hr_q;
                    hr_d      = '0;
                    hr_full_d = 1'b0;
                    cnt_d     = '0;
                end else if (accept) begin
                    sr_d  = bus.in_data;
                    cnt_d = '0;
                end else begin
                    state_d = IDLE;
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from next-state so dout is 0 whenever idle.
        dout_valid_d = (state_d == SHIFT);
        dout_d       = dout_valid_d & sr_d[WIDTH-1];
        last_bit_d   = dout_valid_d && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            hr_q         <= '0;
            hr_full_q    <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            last_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            hr_q         <= hr_d;
            hr_full_q    <= hr_full_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            last_bit_q   <= last_bit_d;
        end
    end
endmodule

// File: tb/tb_bitstream_serializer.sv
// Bench for bitstream_serializer (WIDTH=4): fixed vector table, corner-case
// sequences and random traffic scored against a bit-queue reference model.
module tb_bitstream_serializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitstream_serializer_if #(.WIDTH(W)) bus();
    bitstream_serializer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model: every bit still to be shown, current dout bit at the front.
    bit   bq[$];
    logic m_rdy, m_acc;

    // Downstream 1011 detector fed only by valid bits.
    logic [3:0] hist = '0;
    int         hits = 0;
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            hist = {hist[2:0], bus.dout};
            if (hist == 4'b1011) hits++;
        end
    end

    typedef struct {
        logic         rst;
        logic         vld;
        logic [W-1:0] data;
        logic         rdy;
        logic         dv;
        logic         d;
        logic         last;
        logic         busy;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, sample in_ready before the edge, advance the model.
    task automatic cyc(input logic r, input logic v, input logic [W-1:0] dt, output logic rdy_o);
        @(negedge clk);
        reset        = r;
        bus.in_valid = v;
        bus.in_data  = dt;
        #1;
        rdy_o = bus.in_ready;
        m_rdy = !r && (bq.size() <= W);
        m_acc = v && m_rdy;
        @(posedge clk);
        if (r) bq.delete();
        else begin
            if (bq.size() > 0) void'(bq.pop_front());
            if (m_acc) for (int b = W - 1; b >= 0; b--) bq.push_back(dt[b]);
        end
        #1;
    endtask

    task automatic step(input logic r, input logic v, input logic [W-1:0] dt);
        logic rdy;
        int   sz;
        cyc(r, v, dt, rdy);
        sz = bq.size();
        chk("in_ready", rdy, m_rdy);
        chk("dout_valid", bus.dout_valid, sz > 0);
        chk("dout", bus.dout, (sz > 0) ? logic'(bq[0]) : 1'b0);
        chk("last_bit", bus.last_bit, (sz > 0) && (sz % W == 1));
        chk("busy", bus.busy, sz > 0);
    endtask

    initial begin
        logic         rdy;
        logic [W-1:0] words[3];
        int           h0, dvc, n;

        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        //            rst   vld   data     rdy   dv    d     last  busy
        tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Single word, then back-to-back through the holding register.
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].vld, tbl[i].data, rdy);
            chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_dv", i), bus.dout_valid, tbl[i].dv);
            chk($sformatf("tbl%0d_dout", i), bus.dout, tbl[i].d);
            chk($sformatf("tbl%0d_last", i), bus.last_bit, tbl[i].last);
            chk($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
        end
        chki("tbl_hits", hits, 2);

        // in_valid held high across three words: 12 contiguous bits, two hits.
        words[0] = 4'b1011; words[1] = 4'b1011; words[2] = 4'b0000;
        h0 = hits;
        dvc = 0;
        for (int k = 0; k < 3; k++) begin
            for (n = 0; n < 20; n++) begin
                step(1'b0, 1'b1, words[k]);
                if (bus.dout_valid) dvc++;
                if (m_acc) break;
            end
            if (n == 20) chki("accept_timeout", n, 0);
        end
        for (n = 0; n < 20; n++) begin
            step(1'b0, 1'b0, 4'b0000);
            if (!bus.dout_valid) break;
            dvc++;
        end
        chki("stream_len", dvc, 12);
        chki("stream_hits", hits - h0, 2);

        // Reset mid-word with the holding register full.
        step(1'b0, 1'b1, 4'b1011);
        step(1'b0, 1'b1, 4'b0110);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0000);

        // Idle with toggling data.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, W'($urandom));

        // Reset coincident with a valid word: dropped.
        step(1'b1, 1'b1, 4'b1011);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b1111);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom % 50) == 0, ($urandom % 4) != 0, W'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
